// File: rtl/led_scan2.sv
// Two-digit multiplexed 7-segment scan driver for a common-anode display.
// Alternates the units and tens digits on a shared active-low segment bus.
// Each slot opens with a dark dead time to prevent ghosting between digits.
// Segment codes are captured once per frame, so a frame never mixes old and new values.
// Optional leading-zero blanking darkens the tens digit when it would show "0".
//
// Handshake note: this block has no valid/ready handshake. Inputs are plain
// levels. seg_hi and seg_lo are sampled only on frame-start edges. en and lzb
// are sampled on every rising edge of ck.
module led_scan2 #(
  parameter int DIV   = 25000,
  parameter int BLANK = 250
) (
  input  logic       ck,
  input  logic       rs,
  input  logic       en,
  input  logic [7:0] seg_hi,
  input  logic [7:0] seg_lo,
  input  logic       lzb,
  output logic [7:0] seg,
  output logic [1:0] dig,
  output logic       frame_tick,
  output logic [1:0] dbg_state
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  localparam logic [7:0] SEG_DARK = 8'hFF;
  localparam logic [7:0] SEG_ZERO = 8'hC0;
  localparam logic [1:0] DIG_OFF  = 2'b11;
  localparam logic [1:0] DIG_LO   = 2'b10;
  localparam logic [1:0] DIG_HI   = 2'b01;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic [7:0]    snap_hi_q, snap_hi_d;
  logic [7:0]    snap_lo_q, snap_lo_d;
  logic [7:0]    seg_q, seg_d;
  logic [1:0]    dig_q, dig_d;
  logic          frame_tick_q, frame_tick_d;
  logic          lit;

  // Next-state, counter, snapshot and registered-output computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    snap_hi_d    = snap_hi_q;
    snap_lo_d    = snap_lo_q;
    frame_tick_d = 1'b0;
    seg_d        = SEG_DARK;
    dig_d        = DIG_OFF;
    lit          = 1'b0;

    if (!en) begin
      // Dropping en goes dark on this edge. The next enable restarts from slot 0.
      state_d = ST_IDLE;
      cnt_d   = '0;
      sel_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d      = ST_BLANK;
          cnt_d        = '0;
          sel_d        = 1'b0;
          snap_hi_d    = seg_hi;
          snap_lo_d    = seg_lo;
          frame_tick_d = 1'b1;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_ON;
            lit     = 1'b1;
          end
        end
        ST_ON: begin
          if (cnt_q == DIV_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (sel_q) begin
              // The tens slot has ended, so the frame is complete. Take a fresh snapshot.
              sel_d        = 1'b0;
              snap_hi_d    = seg_hi;
              snap_lo_d    = seg_lo;
              frame_tick_d = 1'b1;
            end else begin
              sel_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            lit   = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sel_d   = 1'b0;
        end
      endcase
    end

    // sel does not change on any edge that produces a lit cycle.
    // Reading sel_q here therefore selects the digit that will be shown.
    if (lit) begin
      if (!sel_q) begin
        seg_d = snap_lo_q;
        dig_d = DIG_LO;
      end else if (!(lzb && (snap_hi_q == SEG_ZERO))) begin
        seg_d = snap_hi_q;
        dig_d = DIG_HI;
      end
    end
  end

  // State and output registers. Reset forces the display dark immediately.
  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      snap_hi_q    <= SEG_DARK;
      snap_lo_q    <= SEG_DARK;
      seg_q        <= SEG_DARK;
      dig_q        <= DIG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      snap_hi_q    <= snap_hi_d;
      snap_lo_q    <= snap_lo_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dig        = dig_q;
  assign frame_tick = frame_tick_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_led_scan2.sv
// Self-checking bench for led_scan2 with DIV=8 and BLANK=2.
// The reference model tracks the position inside the frame and the per-frame snapshot.
// It derives the expected display from those two values.
module tb_led_scan2;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 2 * DIV;

  logic       ck;
  logic       rs;
  logic       en;
  logic [7:0] seg_hi;
  logic [7:0] seg_lo;
  logic       lzb;
  logic [7:0] seg;
  logic [1:0] dig;
  logic       frame_tick;
  logic [1:0] dbg_state;

  int n_checks;
  int n_errors;

  // Expected {frame_tick, dig, seg}, one entry per rising edge
  logic [10:0] exp_q[$];

  // Model state
  bit       m_active;
  int       m_pos;
  logic [7:0] m_hi;
  logic [7:0] m_lo;

  logic [7:0] digit_code[10];

  led_scan2 #(.DIV(DIV), .BLANK(BLANK)) dut (
    .ck        (ck),
    .rs        (rs),
    .en        (en),
    .seg_hi    (seg_hi),
    .seg_lo    (seg_lo),
    .lzb       (lzb),
    .seg       (seg),
    .dig       (dig),
    .frame_tick(frame_tick),
    .dbg_state (dbg_state)
  );

  // Clock and initial reset
  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic check_eq(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: frame position and snapshot, sampled on every rising edge
  always @(posedge ck) begin
    logic [10:0] e;
    int slot;
    int off;
    e = {1'b0, 2'b11, 8'hFF};
    if (!rs || !en) begin
      m_active = 1'b0;
    end else begin
      if (!m_active) begin
        m_active = 1'b1;
        m_pos    = 0;
      end else begin
        m_pos = (m_pos + 1) % FRAME;
      end
      if (m_pos == 0) begin
        m_hi = seg_hi;
        m_lo = seg_lo;
      end
      slot = m_pos / DIV;
      off  = m_pos % DIV;
      e[10] = (m_pos == 0);
      if (off >= BLANK) begin
        if (slot == 0)
          e[9:0] = {2'b10, m_lo};
        else if (!(lzb && m_hi == 8'hC0))
          e[9:0] = {2'b01, m_hi};
      end
    end
    exp_q.push_back(e);
  end

  // Scoreboard: compare outputs away from the active edge
  always @(negedge ck) begin
    logic [10:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("seg", {3'b0, seg}, {3'b0, e[7:0]});
      check_eq("dig", {9'b0, dig}, {9'b0, e[9:8]});
      check_eq("frame_tick", {10'b0, frame_tick}, {10'b0, e[10]});
      check_eq("dig_not_both", {10'b0, dig == 2'b00}, 11'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge ck);
  endtask

  task automatic set_count(input int v);
    seg_hi = digit_code[v / 10];
    seg_lo = digit_code[v % 10];
  endtask

  // Stimulus
  initial begin
    digit_code = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    n_checks = 0;
    n_errors = 0;
    m_active = 1'b0;
    m_pos    = 0;
    m_hi     = 8'hFF;
    m_lo     = 8'hFF;
    rs     = 1'b0;
    en     = 1'b0;
    seg_hi = 8'hFF;
    seg_lo = 8'hFF;
    lzb    = 1'b0;
    tick(3);
    rs = 1'b1;
    tick(20);

    // Normal scan
    seg_hi = 8'hF9;
    seg_lo = 8'h92;
    en = 1'b1;
    tick(3 * FRAME);

    // Snapshot coherency: change the units code during the tens slot
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(12);
    seg_lo = 8'h99;
    tick(2 * FRAME);

    // Leading-zero blanking
    seg_hi = 8'hC0;
    seg_lo = 8'h90;
    lzb = 1'b1;
    tick(2 * FRAME);
    lzb = 1'b0;
    tick(2 * FRAME);

    // Enable drop during the units ON phase
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(5);
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(FRAME + 4);

    // Asynchronous reset while a digit is lit
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(4);
    #2 rs = 1'b0;
    #1;
    check_eq("rst_async_seg", {3'b0, seg}, {3'b0, 8'hFF});
    check_eq("rst_async_dig", {9'b0, dig}, {9'b0, 2'b11});
    check_eq("rst_async_ft", {10'b0, frame_tick}, 11'd0);
    tick(2);
    en = 1'b0;
    rs = 1'b1;
    tick(3 * FRAME);
    en = 1'b1;
    tick(FRAME);

    // Countdown 15..0 driven from an upstream counter, with leading-zero blanking
    lzb = 1'b1;
    for (int v = 15; v >= 0; v--) begin
      set_count(v);
      tick(FRAME - 3 + $urandom_range(0, 6));
    end
    tick(2 * FRAME);

    // Randomized operation
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 19) != 0);
      lzb = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) set_count($urandom_range(0, 99));
      if ($urandom_range(0, 15) == 0) seg_lo = 8'($urandom);
      tick(1);
    end
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
